// File: rtl/nr4sdp_pkg.sv
// nr4sdp_pkg: shared constants and types for the NR4SD+ serial decoder.
//   NDIG  - digits per operand (last one is modified-Booth format)
//   W     - reconstructed operand width (2*NDIG)
//   ACC_W - accumulator width; three guard bits so the running sum never wraps
//   CNT_W - digit counter width
package nr4sdp_pkg;

  localparam int NDIG  = 8;
  localparam int W     = 2 * NDIG;
  localparam int ACC_W = W + 3;
  localparam int CNT_W = $clog2(NDIG);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_e;

  // Signed radix-4 digit, range -2..+2.
  typedef logic signed [2:0] digit_t;

  // True when a full-width sum does not fit in signed W bits: the bits from
  // W-1 upward must all equal the sign for the value to be representable.
  function automatic logic acc_ovf(input logic signed [ACC_W-1:0] a);
    logic [ACC_W-W:0] top;
    top = a[ACC_W-1:W-1];
    return !((&top) || (~|top));
  endfunction

endpackage

// File: rtl/nr4sdp_digit_decode.sv
// nr4sdp_digit_decode: combinational decode of one recoded digit.
//   onep_i/onem_i/twop_i - NR4SD+ code bits (used when is_mb_i=0)
//   sign_i/one_i/two_i   - modified-Booth code bits (used when is_mb_i=1)
//   is_mb_i              - selects the MB format (top digit of the operand)
//   digit_o              - signed digit value -2..+2
//   illegal_o            - illegal code seen (only when NR4SDP_ILLEGAL_CHK_EN)
// Build option NR4SDP_ILLEGAL_CHK_EN: when defined, multi-hot codes are
// flagged and decode as 0; otherwise illegal_o is 0 and a priority decode
// (twop>onep>onem, two>one) resolves multi-hot codes.
module nr4sdp_digit_decode
  import nr4sdp_pkg::*;
(
  input  logic   onep_i,
  input  logic   onem_i,
  input  logic   twop_i,
  input  logic   sign_i,
  input  logic   one_i,
  input  logic   two_i,
  input  logic   is_mb_i,
  output digit_t digit_o,
  output logic   illegal_o
);

  always_comb begin
    digit_o   = '0;
    illegal_o = 1'b0;
    if (is_mb_i) begin
      if (two_i)      digit_o = 3'sd2;
      else if (one_i) digit_o = 3'sd1;
      // sign with zero magnitude stays 0, which is a legal encoding
      if (sign_i) digit_o = -digit_o;
`ifdef NR4SDP_ILLEGAL_CHK_EN
      illegal_o = one_i & two_i;
`endif
    end else begin
      if (twop_i)      digit_o = 3'sd2;
      else if (onep_i) digit_o = 3'sd1;
      else if (onem_i) digit_o = -3'sd1;
`ifdef NR4SDP_ILLEGAL_CHK_EN
      illegal_o = (onep_i & onem_i) | (onep_i & twop_i) | (onem_i & twop_i);
`endif
    end
`ifdef NR4SDP_ILLEGAL_CHK_EN
    if (illegal_o) digit_o = '0;
`endif
  end

endmodule

// File: rtl/nr4sdp_serial_decoder.sv
// nr4sdp_serial_decoder: rebuilds a W-bit two's-complement operand from its
// recoded digit stream, one digit per in_valid/in_ready handshake, as
// sum d_i * 4^i. Digits 0..NDIG-2 are NR4SD+, digit NDIG-1 is modified-Booth.
//   clk, rst            - clock, synchronous active-high reset
//   in_valid/in_ready   - digit handshake
//   dig_onep/onem/twop  - NR4SD+ code bits
//   dig_sign/one/two    - MB code bits
//   out_valid/out_ready - result handshake
//   result, ovf, err    - value, signed-range overflow, illegal-code flag
// Build option NR4SDP_ILLEGAL_CHK_EN enables illegal-code detection (err);
// without it err stays 0.
//
// State table:
//   IDLE    | waiting for digit 0
//   COLLECT | accumulating digits 1..NDIG-1
//   DONE    | result presented, input stalled until out_ready
module nr4sdp_serial_decoder
  import nr4sdp_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         dig_onep,
  input  logic         dig_onem,
  input  logic         dig_twop,
  input  logic         dig_sign,
  input  logic         dig_one,
  input  logic         dig_two,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         ovf,
  output logic         err
);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [W-1:0]            result_q, result_d;
  logic                    ovf_q, ovf_d;
  logic                    err_q, err_d;
  logic                    err_frm_q, err_frm_d;

  digit_t                  dig;
  logic                    dig_ill;
  logic                    is_mb;
  logic                    xfer;
  logic                    handoff;
  logic                    in_ready_c;
  logic                    out_valid_c;
  logic signed [ACC_W-1:0] dig_term;
  logic signed [ACC_W-1:0] acc_sum;

  assign is_mb   = (cnt_q == CNT_W'(NDIG - 1));
  assign xfer    = in_valid & in_ready_c;
  assign handoff = out_valid_c & out_ready;

  nr4sdp_digit_decode u_dec (
    .onep_i    (dig_onep),
    .onem_i    (dig_onem),
    .twop_i    (dig_twop),
    .sign_i    (dig_sign),
    .one_i     (dig_one),
    .two_i     (dig_two),
    .is_mb_i   (is_mb),
    .digit_o   (dig),
    .illegal_o (dig_ill)
  );

  // Sign-extend the digit, then weight it by 4^i.
  assign dig_term = {{(ACC_W-3){dig[2]}}, dig} <<< {cnt_q, 1'b0};
  assign acc_sum  = acc_q + dig_term;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, COLLECT: if (xfer) state_d = is_mb ? DONE : COLLECT;
      DONE:          if (out_ready) state_d = IDLE;
      default:       state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready_c  = 1'b1;
    out_valid_c = 1'b0;
    if (state_q == DONE) begin
      in_ready_c  = 1'b0;
      out_valid_c = 1'b1;
    end
  end

  // Datapath next values
  always_comb begin
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    result_d  = result_q;
    ovf_d     = ovf_q;
    err_d     = err_q;
    err_frm_d = err_frm_q;
    if (xfer) begin
      acc_d     = acc_sum;
      err_frm_d = err_frm_q | dig_ill;
      if (is_mb) begin
        // counter parks at NDIG-1 while DONE; it is cleared on handoff
        result_d = acc_sum[W-1:0];
        ovf_d    = acc_ovf(acc_sum);
        err_d    = err_frm_q | dig_ill;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    if (handoff) begin
      cnt_d     = '0;
      acc_d     = '0;
      err_frm_d = 1'b0;
      err_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      result_q  <= '0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
      err_frm_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      result_q  <= result_d;
      ovf_q     <= ovf_d;
      err_q     <= err_d;
      err_frm_q <= err_frm_d;
    end
  end

  assign in_ready  = in_ready_c;
  assign out_valid = out_valid_c;
  assign result    = result_q;
  assign ovf       = ovf_q;
  assign err       = err_q;

endmodule

// File: doc/nr4sdp_serial_decoder.md
Name: nr4sdp_serial_decoder

Overview:
Sequential decoder for the NR4SD+ recoding path. It accepts a multiplier operand's recoded digit stream one digit per handshake: 7 NR4SD+ digits in one_p/one_m/two_p form, then 1 modified-Booth top digit in sign/one/two form. It reconstructs the 16-bit two's-complement value as sum d_i*4^i. It is used as the round-trip checker and as the inverse stage for the recoder in the 32-bit multiplier datapath.

Parameters:
NDIG, 8, total digits per operand; the final digit is MB-format, the others NR4SD+.
W, 16, output width; fixed to 2*NDIG.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  digit present
in_ready  out  1  decoder accepts digit this cycle
dig_onep  in  1  NR4SD+ digit = +1 (digits 0..NDIG-2)
dig_onem  in  1  NR4SD+ digit = -1
dig_twop  in  1  NR4SD+ digit = +2
dig_sign  in  1  MB digit sign (digit NDIG-1)
dig_one  in  1  MB digit magnitude 1
dig_two  in  1  MB digit magnitude 2
out_valid  out  1  result ready
out_ready  in  1  consumer takes result
result  out  W  reconstructed two's-complement value
ovf  out  1  sum outside signed W-bit range
err  out  1  illegal digit code seen in this frame (feature-dependent)

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset values: state=IDLE, digit counter=0, accumulator=0, in_ready=1, out_valid=0, result=0, ovf=0, err=0.
- States and transitions:
  - IDLE/COLLECT: in_ready=1. A transfer occurs when in_valid&in_ready.
  - On each transfer, acc += d_i <<< 2*i, where i is the digit counter. Then the counter increments.
  - The first transfer moves IDLE→COLLECT.
- Digit decode, i<NDIG-1 (NR4SD+):
  - twop → +2; onep → +1; onem → -1; all zero → 0.
  - MB inputs are ignored at these indices.
- Digit decode, i=NDIG-1 (MB):
  - magnitude is two?2:one?1:0; negated if sign.
  - sign with zero magnitude = 0, which is legal.
  - NR4SD+ inputs are ignored at this index.
- Accumulator: 19-bit signed, so no internal wrap.
- End of frame: the transfer of digit NDIG-1 moves to DONE on the next edge.
  - result = acc[W-1:0] (including the final digit).
  - ovf=1 iff the full sum is < -2^(W-1) or > 2^(W-1)-1.
  - Latency: out_valid rises 1 cycle after the last digit transfer.
- DONE: out_valid=1, in_ready=0. result, ovf and err are held stable until out_ready.
  - On out_valid&out_ready: out_valid drops next cycle, counter and acc clear, state→IDLE, in_ready=1.
  - No same-cycle acceptance of a new digit; one bubble cycle per frame.
- in_valid during DONE: ignored, not consumed.
- rst mid-frame: partial accumulation is discarded and all reset values apply on the next edge.
- rst while out_valid: the result is dropped.
- Counter wraps only via DONE; it never exceeds NDIG-1.

Optional Feature:
NR4SDP_ILLEGAL_CHK_EN
- Defined:
  - Illegal codes are two or more of onep/onem/twop high (NR4SD+ index), or one&two both high (MB index).
  - An illegal code sets a sticky err for the frame.
  - The offending digit is decoded as 0.
  - err is presented with result and cleared on frame handoff or rst.
- Undefined:
  - err is tied 0.
  - Priority decode is used: twop>onep>onem; two>one.

Decomposition:
- Package nr4sdp_pkg:
  - NDIG, W, ACC_W=W+3.
  - State enum {IDLE, COLLECT, DONE}.
  - Signed digit type (3-bit, -2..+2).
- Sub-module nr4sdp_digit_decode (combinational):
  - Inputs: six code bits and is_mb.
  - Outputs: 3-bit signed digit and illegal flag.
- Top level: FSM, counter, shifted accumulate, output regs.

Test Plan:
1. All 8 digits zero, out_ready=1 → out_valid one cycle after the 8th transfer; result=0x0000, ovf=0, err=0.
2. d0=+2 (twop), d3=-1 (onem), rest 0 → result=2-64=-62=0xFFC2, ovf=0.
3. d7=MB -2 (sign,two), rest 0 → result=0x8000, ovf=0. Then d7=+2, rest 0 → result=0x8000, ovf=1.
4. Backpressure: out_ready=0 for 5 cycles after a frame → result/out_valid held, in_ready=0, extra in_valid digits not consumed. Raise out_ready → next frame is accepted starting from digit 0.
5. rst asserted after 4 digits → next cycle all outputs at reset values. A fresh 8-digit frame d1=+1 (others 0) → result=4.
6. With NR4SDP_ILLEGAL_CHK_EN: d2 onep&onem, d5=+1 → result=1024, err=1. Same stimulus without the macro → d2 decodes +1, result=1040, err=0.
